// File: rtl/tcdm_amo_lrsc_shim.sv
// -----------------------------------------------------------------------------
// tcdm_amo_lrsc_shim
//
// Sits between one TCDM requester port and one SRAM bank and adds:
//   - 32-bit atomics (swap/add/and/or/xor/max/maxu/min/minu). Each one is a
//     read in Idle followed by a write-back in DoAMO.
//   - LR/SC with one reservation entry per requester ID. An LR is a plain read
//     that records {word address, lane} for its ID. An SC is settled in a
//     single Idle cycle and its status word is returned on the next cycle.
//   - Invalidation of reservations by every SRAM write that touches a reserved
//     lane, whoever issued the write.
//
// Handshake: a request is accepted in any cycle where in_req_i is high and
// in_gnt_o is high. in_gnt_o is low only during DoAMO, and a requester must
// hold its request stable until it is granted. Every accepted request returns
// exactly one response: in_rvalid_o is high one cycle later. For an atomic
// this is the DoAMO cycle.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   in_req_i/in_gnt_o                  requester request/grant
//   in_add_i, in_amo_i, in_id_i        word address, operation code, requester ID
//   in_wen_i, in_wdata_i, in_be_i      store flag, write data, byte enables
//   in_rvalid_o, in_rdata_o            response valid and data
//   out_req_o, out_add_o, out_wen_o    SRAM request, address, write enable
//   out_wdata_o, out_be_o              SRAM write data and byte enables
//   out_rdata_i                        SRAM read data, one cycle after the read
// -----------------------------------------------------------------------------
module tcdm_amo_lrsc_shim #(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumResv      = 8,
  parameter int unsigned IdWidth      = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_req_i,
  output logic                      in_gnt_o,
  input  logic [AddrMemWidth-1:0]   in_add_i,
  input  logic [3:0]                in_amo_i,
  input  logic [IdWidth-1:0]        in_id_i,
  input  logic                      in_wen_i,
  input  logic [DataWidth-1:0]      in_wdata_i,
  input  logic [DataWidth/8-1:0]    in_be_i,
  output logic                      in_rvalid_o,
  output logic [DataWidth-1:0]      in_rdata_o,
  output logic                      out_req_o,
  output logic [AddrMemWidth-1:0]   out_add_o,
  output logic                      out_wen_o,
  output logic [DataWidth-1:0]      out_wdata_o,
  output logic [DataWidth/8-1:0]    out_be_o,
  input  logic [DataWidth-1:0]      out_rdata_i
);

  localparam int NumLanes = int'(DataWidth / 32);
  localparam int LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam int BeW      = int'(DataWidth / 8);
  localparam int ResvW    = int'(AddrMemWidth) + LaneW;
  localparam int NResv    = int'(NumResv);

  typedef enum logic [3:0] {
    OP_NONE = 4'h0,
    OP_SWAP = 4'h1,
    OP_ADD  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_MAX  = 4'h6,
    OP_MAXU = 4'h7,
    OP_MIN  = 4'h8,
    OP_MINU = 4'h9,
    OP_LR   = 4'hA,
    OP_SC   = 4'hB
  } amo_op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DOAMO = 1'b1
  } state_e;

  // Selects how in_rdata_o is built for the response that is in flight.
  typedef enum logic [1:0] {
    RESP_PLAIN = 2'd0,
    RESP_AMO   = 2'd1,
    RESP_SC    = 2'd2
  } resp_e;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------
  function automatic logic [BeW-1:0] lane_mask(input logic [LaneW-1:0] l);
    lane_mask = '0;
    for (int k = 0; k < NumLanes; k++) begin
      if (LaneW'(k) == l) lane_mask[4*k +: 4] = 4'hF;
    end
  endfunction

  function automatic logic [31:0] lane_word(input logic [DataWidth-1:0] d,
                                            input logic [LaneW-1:0]     l);
    lane_word = '0;
    for (int k = 0; k < NumLanes; k++) begin
      if (LaneW'(k) == l) lane_word = d[32*k +: 32];
    end
  endfunction

  // Places a 32-bit value in lane l and zeroes every other lane.
  function automatic logic [DataWidth-1:0] lane_place(input logic [31:0]      v,
                                                      input logic [LaneW-1:0] l);
    lane_place = '0;
    for (int k = 0; k < NumLanes; k++) begin
      if (LaneW'(k) == l) lane_place[32*k +: 32] = v;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e                   r_state;
  amo_op_e                  r_op;
  resp_e                    r_resp;
  logic                     r_rvalid;
  logic                     r_sc_fail;
  logic [AddrMemWidth-1:0]  r_addr;
  logic [LaneW-1:0]         r_lane;
  logic [31:0]              r_operand;
  logic [NResv-1:0]         r_resv_valid;
  logic [ResvW-1:0]         r_resv_addr [NResv];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  amo_op_e                  w_op;
  logic [LaneW-1:0]         w_lane;
  logic                     w_is_amo;
  logic                     w_acc;
  logic                     w_sc_ok;
  logic [NResv-1:0]         w_kill;
  logic                     w_wr;

  // Codes C..F fall back to a plain access.
  assign w_op     = (in_amo_i > 4'hB) ? OP_NONE : amo_op_e'(in_amo_i);
  assign w_is_amo = (w_op != OP_NONE) && (w_op != OP_LR) && (w_op != OP_SC);
  assign w_acc    = (r_state == S_IDLE) && in_req_i;

  // The lowest lane whose first byte is enabled.
  always_comb begin
    w_lane = '0;
    for (int k = NumLanes - 1; k >= 0; k--) begin
      if (in_be_i[4*k]) w_lane = LaneW'(k);
    end
  end

  // The SC succeeds only if the entry for its own ID holds exactly this word
  // and lane. IDs that have no entry never match.
  always_comb begin
    w_sc_ok = 1'b0;
    for (int i = 0; i < NResv; i++) begin
      if ((in_id_i == IdWidth'(i)) && r_resv_valid[i] &&
          (r_resv_addr[i] == {in_add_i, w_lane})) begin
        w_sc_ok = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ALU: 32-bit. The min/max compare uses a 33-bit subtract whose sign bit
  // gives a < b; the operands are sign-extended only for MAX/MIN.
  // ---------------------------------------------------------------------------
  logic [31:0] w_old;
  logic [31:0] w_alu;
  logic [32:0] w_a_ext;
  logic [32:0] w_b_ext;
  logic [32:0] w_diff;
  logic        w_signed;
  logic        w_a_lt_b;

  assign w_old    = lane_word(out_rdata_i, r_lane);
  assign w_signed = (r_op == OP_MAX) || (r_op == OP_MIN);
  assign w_a_ext  = {w_signed & w_old[31], w_old};
  assign w_b_ext  = {w_signed & r_operand[31], r_operand};
  assign w_diff   = w_a_ext - w_b_ext;
  assign w_a_lt_b = w_diff[32];

  always_comb begin
    w_alu = w_old;
    case (r_op)
      OP_SWAP:         w_alu = r_operand;
      OP_ADD:          w_alu = w_old + r_operand;
      OP_AND:          w_alu = w_old & r_operand;
      OP_OR:           w_alu = w_old | r_operand;
      OP_XOR:          w_alu = w_old ^ r_operand;
      OP_MAX, OP_MAXU: w_alu = w_a_lt_b ? r_operand : w_old;
      OP_MIN, OP_MINU: w_alu = w_a_lt_b ? w_old : r_operand;
      default:         w_alu = w_old;
    endcase
  end

  // ---------------------------------------------------------------------------
  // SRAM port and grant
  // ---------------------------------------------------------------------------
  always_comb begin
    in_gnt_o    = 1'b0;
    out_req_o   = 1'b0;
    out_add_o   = in_add_i;
    out_wen_o   = 1'b0;
    out_wdata_o = in_wdata_i;
    out_be_o    = in_be_i;
    if (r_state == S_DOAMO) begin
      // Write-back of the atomic. New requests are held off for this cycle.
      out_req_o   = 1'b1;
      out_add_o   = r_addr;
      out_wen_o   = 1'b1;
      out_be_o    = lane_mask(r_lane);
      out_wdata_o = lane_place(w_alu, r_lane);
    end else begin
      in_gnt_o = in_req_i;
      if (w_op == OP_NONE) begin
        out_req_o = in_req_i;
        out_wen_o = in_wen_i;
      end else if (w_op == OP_SC) begin
        // A failed SC never reaches the SRAM.
        out_req_o = in_req_i && w_sc_ok;
        out_wen_o = 1'b1;
        out_be_o  = lane_mask(w_lane);
      end else begin
        // LR and the read phase of an atomic.
        out_req_o = in_req_i;
        out_wen_o = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response
  // ---------------------------------------------------------------------------
  assign in_rvalid_o = r_rvalid;

  always_comb begin
    case (r_resp)
      RESP_AMO: in_rdata_o = lane_place(w_old, r_lane);
      RESP_SC:  in_rdata_o = lane_place({31'b0, r_sc_fail}, r_lane);
      default:  in_rdata_o = out_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_op      <= OP_NONE;
      r_resp    <= RESP_PLAIN;
      r_rvalid  <= 1'b0;
      r_sc_fail <= 1'b0;
      r_addr    <= '0;
      r_lane    <= '0;
      r_operand <= '0;
    end else begin
      r_rvalid <= w_acc;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_op      <= w_op;
            r_addr    <= in_add_i;
            r_lane    <= w_lane;
            r_operand <= lane_word(in_wdata_i, w_lane);
            r_sc_fail <= !w_sc_ok;
            if (w_is_amo) begin
              r_resp  <= RESP_AMO;
              r_state <= S_DOAMO;
            end else if (w_op == OP_SC) begin
              r_resp  <= RESP_SC;
            end else begin
              r_resp  <= RESP_PLAIN;
            end
          end
        end
        S_DOAMO: begin
          r_op    <= OP_NONE;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Reservations
  // ---------------------------------------------------------------------------
  assign w_wr = out_req_o && out_wen_o;

  // A write kills every entry on the same word whose lane has any byte
  // written, including the writer's own entry.
  always_comb begin
    for (int i = 0; i < NResv; i++) begin
      w_kill[i] = w_wr && r_resv_valid[i] &&
                  (r_resv_addr[i][ResvW-1:LaneW] == out_add_o) &&
                  (|(out_be_o & lane_mask(r_resv_addr[i][LaneW-1:0])));
    end
  end

  // An LR never coincides with a write, and a successful SC clears its own
  // entry through both the kill and the SC clear, so the order below is safe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resv_valid <= '0;
      for (int i = 0; i < NResv; i++) r_resv_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NResv; i++) begin
        if (w_kill[i]) r_resv_valid[i] <= 1'b0;
        if (w_acc && (w_op == OP_SC) && (in_id_i == IdWidth'(i))) begin
          r_resv_valid[i] <= 1'b0;
        end
        if (w_acc && (w_op == OP_LR) && (in_id_i == IdWidth'(i))) begin
          r_resv_valid[i] <= 1'b1;
          r_resv_addr[i]  <= {in_add_i, w_lane};
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_amo_lrsc_shim.sv
// -----------------------------------------------------------------------------
// Testbench for tcdm_amo_lrsc_shim with the default parameters (64-bit bank,
// two lanes). A small SRAM model answers reads one cycle late. The atomics are
// driven from a table of vectors with hand-computed results. LR/SC,
// invalidation, stall and reset corner cases are written out as sequences.
// -----------------------------------------------------------------------------
module tb_tcdm_amo_lrsc_shim;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 3;
  localparam int BW = DW / 8;

  // clock / reset
  logic clk;
  logic rst_ni;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           in_req_i;
  logic           in_gnt_o;
  logic [AW-1:0]  in_add_i;
  logic [3:0]     in_amo_i;
  logic [IW-1:0]  in_id_i;
  logic           in_wen_i;
  logic [DW-1:0]  in_wdata_i;
  logic [BW-1:0]  in_be_i;
  logic           in_rvalid_o;
  logic [DW-1:0]  in_rdata_o;
  logic           out_req_o;
  logic [AW-1:0]  out_add_o;
  logic           out_wen_o;
  logic [DW-1:0]  out_wdata_o;
  logic [BW-1:0]  out_be_o;
  logic [DW-1:0]  out_rdata_i;

  tcdm_amo_lrsc_shim #(
    .AddrMemWidth(AW), .DataWidth(DW), .NumResv(8), .IdWidth(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
    .in_amo_i(in_amo_i), .in_id_i(in_id_i), .in_wen_i(in_wen_i),
    .in_wdata_i(in_wdata_i), .in_be_i(in_be_i),
    .in_rvalid_o(in_rvalid_o), .in_rdata_o(in_rdata_o),
    .out_req_o(out_req_o), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
    .out_wdata_o(out_wdata_o), .out_be_o(out_be_o), .out_rdata_i(out_rdata_i)
  );

  // SRAM model: 64 words, byte-enabled writes, registered read data.
  logic [DW-1:0] mem [64];
  logic [5:0]    mem_idx;
  assign mem_idx = out_add_o[5:0];
  initial out_rdata_i = '0;
  always @(posedge clk) begin
    if (out_req_o) begin
      if (out_wen_o) begin
        for (int b = 0; b < BW; b++) begin
          if (out_be_o[b]) mem[mem_idx][8*b +: 8] <= out_wdata_o[8*b +: 8];
        end
      end else begin
        out_rdata_i <= mem[mem_idx];
      end
    end
  end

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_mask(input int lane);
    return (lane == 1) ? 8'hF0 : 8'h0F;
  endfunction

  function automatic logic [63:0] tb_place(input logic [31:0] v, input int lane);
    return (lane == 1) ? {v, 32'h0} : {32'h0, v};
  endfunction

  // driver tasks
  task automatic set_idle();
    in_req_i   = 1'b0;
    in_amo_i   = 4'h0;
    in_id_i    = '0;
    in_add_i   = '0;
    in_wen_i   = 1'b0;
    in_wdata_i = '0;
    in_be_i    = '0;
  endtask

  task automatic drive(input logic [3:0] amo, input logic [IW-1:0] id, input logic [AW-1:0] add,
                       input logic wen, input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    in_req_i   = 1'b1;
    in_amo_i   = amo;
    in_id_i    = id;
    in_add_i   = add;
    in_wen_i   = wen;
    in_wdata_i = wdata;
    in_be_i    = be;
  endtask

  task automatic do_store(input logic [IW-1:0] id, input logic [AW-1:0] add,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    @(negedge clk);
    drive(4'h0, id, add, 1'b1, wdata, be);
    #1;
    check1("st_gnt", in_gnt_o, 1'b1);
    check1("st_wen", out_wen_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    check1("st_rvalid", in_rvalid_o, 1'b1);
  endtask

  // Plain load (amo = 0) or LR (amo = A).
  task automatic do_load(input string name, input logic [3:0] amo, input logic [IW-1:0] id,
                         input logic [AW-1:0] add, input logic [BW-1:0] be,
                         input logic [DW-1:0] exp);
    @(negedge clk);
    drive(amo, id, add, 1'b0, '0, be);
    #1;
    check1({name, "_gnt"}, in_gnt_o, 1'b1);
    check1({name, "_req"}, out_req_o, 1'b1);
    check1({name, "_wen"}, out_wen_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    check1({name, "_rvalid"}, in_rvalid_o, 1'b1);
    check({name, "_rdata"}, in_rdata_o, exp);
  endtask

  task automatic do_sc(input string name, input logic [IW-1:0] id, input logic [AW-1:0] add,
                       input int lane, input logic [31:0] wdata, input logic exp_fail);
    @(negedge clk);
    drive(4'hB, id, add, 1'b1, tb_place(wdata, lane), tb_mask(lane));
    #1;
    check1({name, "_gnt"}, in_gnt_o, 1'b1);
    check1({name, "_req"}, out_req_o, !exp_fail);
    if (!exp_fail) begin
      check1({name, "_wen"}, out_wen_o, 1'b1);
      check({name, "_be"}, 64'(out_be_o), 64'(tb_mask(lane)));
    end
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    check1({name, "_rvalid"}, in_rvalid_o, 1'b1);
    check({name, "_rdata"}, in_rdata_o, tb_place({31'b0, exp_fail}, lane));
  endtask

  task automatic do_amo(input string name, input logic [3:0] op, input int lane,
                        input logic [AW-1:0] add, input logic [31:0] operand,
                        input logic [31:0] exp_old, input logic [31:0] exp_new);
    logic [31:0] wlane;
    @(negedge clk);
    drive(op, 3'd0, add, 1'b0, tb_place(operand, lane), tb_mask(lane));
    #1;
    check1({name, "_rd_gnt"}, in_gnt_o, 1'b1);
    check1({name, "_rd_req"}, out_req_o, 1'b1);
    check1({name, "_rd_wen"}, out_wen_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    wlane = (lane == 1) ? out_wdata_o[63:32] : out_wdata_o[31:0];
    check1({name, "_wr_req"}, out_req_o, 1'b1);
    check1({name, "_wr_wen"}, out_wen_o, 1'b1);
    check({name, "_wr_add"}, 64'(out_add_o), 64'(add));
    check({name, "_wr_be"}, 64'(out_be_o), 64'(tb_mask(lane)));
    check({name, "_wr_data"}, 64'(wlane), 64'(exp_new));
    check1({name, "_rvalid"}, in_rvalid_o, 1'b1);
    check({name, "_rdata"}, in_rdata_o, tb_place(exp_old, lane));
  endtask

  // vector table for the atomics
  typedef struct {
    logic [3:0]  op;
    int          lane;
    logic [31:0] old;
    logic [31:0] operand;
    logic [31:0] exp_new;
  } amo_vec_t;

  amo_vec_t vecs [12];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'h1, 0, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF}; // swap
    vecs[1]  = '{4'h2, 1, 32'h0000_0010, 32'h0000_0005, 32'h0000_0015}; // add lane 1
    vecs[2]  = '{4'h2, 0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001}; // add wraps
    vecs[3]  = '{4'h3, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000}; // and
    vecs[4]  = '{4'h4, 0, 32'hF0F0_0000, 32'h0F0F_0001, 32'hFFFF_0001}; // or
    vecs[5]  = '{4'h5, 1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F}; // xor
    vecs[6]  = '{4'h6, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001}; // max: -1 vs 1
    vecs[7]  = '{4'h7, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF}; // maxu
    vecs[8]  = '{4'h8, 1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF}; // min
    vecs[9]  = '{4'h9, 1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001}; // minu
    vecs[10] = '{4'h6, 0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF}; // max at sign edge
    vecs[11] = '{4'h9, 0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF}; // minu at sign edge

    // reset state; address and write enable feed through while in reset
    set_idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check1("rst_rvalid", in_rvalid_o, 1'b0);
    check1("rst_out_req", out_req_o, 1'b0);
    check1("rst_gnt", in_gnt_o, 1'b0);
    in_add_i = 32'h0000_002A;
    in_wen_i = 1'b1;
    #1;
    check("rst_add_feed", 64'(out_add_o), 64'h2A);
    check1("rst_wen_feed", out_wen_o, 1'b1);
    set_idle();
    @(negedge clk);
    rst_ni = 1'b1;

    // atomics from the table: preload, atomic, then read back the whole word
    for (int i = 0; i < 12; i++) begin
      logic [63:0] fill;
      fill = tb_place(vecs[i].old, vecs[i].lane) | tb_place(32'hA5A5_A5A5, 1 - vecs[i].lane);
      do_store(3'd0, 32'(16 + i), fill, 8'hFF);
      do_amo($sformatf("amo%0d", i), vecs[i].op, vecs[i].lane, 32'(16 + i),
             vecs[i].operand, vecs[i].old, vecs[i].exp_new);
      do_load($sformatf("amo%0d_mem", i), 4'h0, 3'd0, 32'(16 + i), 8'hFF,
              tb_place(vecs[i].exp_new, vecs[i].lane) | tb_place(32'hA5A5_A5A5, 1 - vecs[i].lane));
    end

    // codes above B behave like plain accesses
    do_store(3'd0, 32'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
    do_load("code_f_ld", 4'hF, 3'd0, 32'd3, 8'hFF, 64'h0123_4567_89AB_CDEF);

    // LR then SC from ID 2, then a repeat SC that must fail
    do_store(3'd0, 32'd4, 64'h1111_1111_2222_2222, 8'hFF);
    do_load("lr2", 4'hA, 3'd2, 32'd4, 8'h0F, 64'h1111_1111_2222_2222);
    do_sc("sc2_ok", 3'd2, 32'd4, 0, 32'hABCD_0123, 1'b0);
    do_load("sc2_mem", 4'h0, 3'd0, 32'd4, 8'hFF, 64'h1111_1111_ABCD_0123);
    do_sc("sc2_again", 3'd2, 32'd4, 0, 32'h5555_5555, 1'b1);
    do_sc("sc5_nores", 3'd5, 32'd4, 1, 32'h5555_5555, 1'b1);

    // another ID storing to the reserved lane breaks the reservation
    do_store(3'd0, 32'd5, 64'h0, 8'hFF);
    do_load("lr1", 4'hA, 3'd1, 32'd5, 8'hF0, 64'h0);
    do_store(3'd3, 32'd5, 64'h7777_7777_0000_0000, 8'hF0);
    do_sc("sc1_killed", 3'd1, 32'd5, 1, 32'h1, 1'b1);

    // a store to the other lane of that word leaves it intact
    do_load("lr1b", 4'hA, 3'd1, 32'd5, 8'hF0, 64'h7777_7777_0000_0000);
    do_store(3'd3, 32'd5, 64'h0000_0000_6666_6666, 8'h0F);
    do_sc("sc1_other_lane", 3'd1, 32'd5, 1, 32'h9999_9999, 1'b0);
    do_load("sc1_mem", 4'h0, 3'd0, 32'd5, 8'hFF, 64'h9999_9999_6666_6666);

    // a lane mismatch fails, and that failed SC still clears the entry
    do_load("lr4", 4'hA, 3'd4, 32'd5, 8'h0F, 64'h9999_9999_6666_6666);
    do_sc("sc4_lane", 3'd4, 32'd5, 1, 32'h0, 1'b1);
    do_sc("sc4_cleared", 3'd4, 32'd5, 0, 32'h0, 1'b1);

    // a DoAMO commit invalidates a reservation held by another ID
    do_store(3'd0, 32'd9, 64'h0000_0000_0000_0007, 8'hFF);
    do_load("lr6", 4'hA, 3'd6, 32'd9, 8'h0F, 64'h7);
    do_amo("amo_kill", 4'h2, 0, 32'd9, 32'h1, 32'h7, 32'h8);
    do_sc("sc6_killed", 3'd6, 32'd9, 0, 32'h0, 1'b1);

    // a successful SC invalidates another ID's reservation on the same lane
    do_store(3'd0, 32'd10, 64'h0, 8'hFF);
    do_load("lr1c", 4'hA, 3'd1, 32'd10, 8'h0F, 64'h0);
    do_load("lr2c", 4'hA, 3'd2, 32'd10, 8'h0F, 64'h0);
    do_sc("sc1c_ok", 3'd1, 32'd10, 0, 32'h11, 1'b0);
    do_sc("sc2c_killed", 3'd2, 32'd10, 0, 32'h22, 1'b1);

    // back-to-back atomic and load: the load waits out the DoAMO cycle
    do_store(3'd0, 32'd12, 64'h0000_0000_0000_0010, 8'hFF);
    @(negedge clk);
    drive(4'h2, 3'd0, 32'd12, 1'b0, 64'h5, 8'h0F);
    #1;
    check1("b2b_amo_gnt", in_gnt_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'h0, 3'd0, 32'd12, 1'b0, 64'h0, 8'hFF);
    #1;
    check1("b2b_stall_gnt", in_gnt_o, 1'b0);
    check1("b2b_stall_wen", out_wen_o, 1'b1);
    check1("b2b_amo_rvalid", in_rvalid_o, 1'b1);
    check("b2b_amo_rdata", in_rdata_o, 64'h10);
    @(posedge clk);
    @(negedge clk);
    #1;
    check1("b2b_ld_gnt", in_gnt_o, 1'b1);
    check1("b2b_ld_req", out_req_o, 1'b1);
    check1("b2b_ld_wen", out_wen_o, 1'b0);
    check1("b2b_ld_rvalid_early", in_rvalid_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    check1("b2b_ld_rvalid", in_rvalid_o, 1'b1);
    check("b2b_ld_rdata", in_rdata_o, 64'h15);

    // reset during DoAMO: no write-back, reservations gone
    do_store(3'd0, 32'd13, 64'h100, 8'hFF);
    do_store(3'd0, 32'd14, 64'h0, 8'hFF);
    do_load("lr0", 4'hA, 3'd0, 32'd14, 8'h0F, 64'h0);
    @(negedge clk);
    drive(4'h2, 3'd0, 32'd13, 1'b0, 64'h1, 8'h0F);
    #1;
    check1("rstamo_gnt", in_gnt_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    rst_ni = 1'b0;
    #1;
    check1("rstamo_req", out_req_o, 1'b0);
    check1("rstamo_wen", out_wen_o, 1'b0);
    check1("rstamo_rvalid", in_rvalid_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    do_load("rstamo_mem", 4'h0, 3'd0, 32'd13, 8'hFF, 64'h100);
    do_sc("rstamo_sc", 3'd0, 32'd14, 0, 32'h1, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
